// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data_memory arbiter: owner FSM encodings and
// small helpers used by the grant and state logic.
package data_memory_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // Owner state that corresponds to a granted port index.
    function automatic logic [1:0] owner_of(input logic port);
        logic [1:0] st;
        if (port) begin
            st = ST_OWN1;
        end else begin
            st = ST_OWN0;
        end
        return st;
    endfunction

endpackage

// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data_memory.
// Grants at most one request per cycle, bounds owner bursts, registers responses.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,

    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    localparam int              BW        = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]   BURST_MAX = BW'(MAX_BURST);
    localparam logic [BW-1:0]   BURST_ONE = BW'(1);

    logic [1:0]            owner_r;
    logic [BW-1:0]         burst_cnt_r;
    logic                  rr_last_r;

    logic                  burst_full_s;
    logic                  gnt_raw_s;
    logic                  gnt_port_s;
    logic                  accept_s;
    logic                  sel_we_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;
    logic [BW-1:0]         burst_next_s;

    function automatic logic [BW-1:0] sat_inc(input logic [BW-1:0] cnt);
        logic [BW-1:0] nxt;
        if (cnt >= BURST_MAX) begin
            nxt = BURST_MAX;
        end else begin
            nxt = cnt + BURST_ONE;
        end
        return nxt;
    endfunction

    assign burst_full_s = (burst_cnt_r == BURST_MAX);

    // Grant selection: owner keeps the port until its burst is spent and the other port waits.
    always_comb begin
        gnt_raw_s  = 1'b0;
        gnt_port_s = 1'b0;
        case (owner_r)
            ST_OWN0: begin
                if (req0_valid && !(req1_valid && burst_full_s)) begin
                    gnt_raw_s  = 1'b1;
                    gnt_port_s = 1'b0;
                end else if (req1_valid) begin
                    gnt_raw_s  = 1'b1;
                    gnt_port_s = 1'b1;
                end else begin
                    gnt_raw_s  = 1'b0;
                    gnt_port_s = 1'b0;
                end
            end
            ST_OWN1: begin
                if (req1_valid && !(req0_valid && burst_full_s)) begin
                    gnt_raw_s  = 1'b1;
                    gnt_port_s = 1'b1;
                end else if (req0_valid) begin
                    gnt_raw_s  = 1'b1;
                    gnt_port_s = 1'b0;
                end else begin
                    gnt_raw_s  = 1'b0;
                    gnt_port_s = 1'b0;
                end
            end
            default: begin
                // IDLE (and any illegal encoding): ties go to the port not served last.
                if (req0_valid && req1_valid) begin
                    gnt_raw_s  = 1'b1;
                    gnt_port_s = ~rr_last_r;
                end else if (req0_valid) begin
                    gnt_raw_s  = 1'b1;
                    gnt_port_s = 1'b0;
                end else if (req1_valid) begin
                    gnt_raw_s  = 1'b1;
                    gnt_port_s = 1'b1;
                end else begin
                    gnt_raw_s  = 1'b0;
                    gnt_port_s = 1'b0;
                end
            end
        endcase
    end

    // Suppress all accepts while reset is held so the memory cannot be written.
    always_comb begin
        if (!rst_n) begin
            accept_s = 1'b0;
        end else begin
            accept_s = gnt_raw_s;
        end
    end

    // Request mux feeding the memory.
    always_comb begin
        if (gnt_port_s) begin
            sel_we_s    = req1_we;
            sel_addr_s  = req1_addr;
            sel_wdata_s = req1_wdata;
        end else begin
            sel_we_s    = req0_we;
            sel_addr_s  = req0_addr;
            sel_wdata_s = req0_wdata;
        end
    end

    // Memory drive and ready handshake; everything is zero when nothing is accepted.
    always_comb begin
        if (accept_s) begin
            mem_address    = sel_addr_s;
            mem_write_data = sel_wdata_s;
            mem_write      = sel_we_s;
            mem_read       = ~sel_we_s;
            req0_ready     = ~gnt_port_s;
            req1_ready     = gnt_port_s;
        end else begin
            mem_address    = {ADDR_WIDTH{1'b0}};
            mem_write_data = {DATA_WIDTH{1'b0}};
            mem_write      = 1'b0;
            mem_read       = 1'b0;
            req0_ready     = 1'b0;
            req1_ready     = 1'b0;
        end
    end

    // Burst count continues only when the current owner is granted again.
    always_comb begin
        if (owner_r == owner_of(gnt_port_s)) begin
            burst_next_s = sat_inc(burst_cnt_r);
        end else begin
            burst_next_s = BURST_ONE;
        end
    end

    // Owner FSM, burst counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r     <= ST_IDLE;
            burst_cnt_r <= {BW{1'b0}};
            rr_last_r   <= 1'b1;
        end else if (accept_s) begin
            owner_r     <= owner_of(gnt_port_s);
            burst_cnt_r <= burst_next_s;
            rr_last_r   <= gnt_port_s;
        end else begin
            owner_r     <= ST_IDLE;
            burst_cnt_r <= {BW{1'b0}};
            rr_last_r   <= rr_last_r;
        end
    end

    // Response pulses and read data capture, one cycle after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= {DATA_WIDTH{1'b0}};
            rsp1_rdata <= {DATA_WIDTH{1'b0}};
        end else begin
            rsp0_valid <= accept_s & ~gnt_port_s;
            rsp1_valid <= accept_s & gnt_port_s;
            if (accept_s && !sel_we_s && !gnt_port_s) begin
                rsp0_rdata <= mem_read_data;
            end else begin
                rsp0_rdata <= rsp0_rdata;
            end
            if (accept_s && !sel_we_s && gnt_port_s) begin
                rsp1_rdata <= mem_read_data;
            end else begin
                rsp1_rdata <= rsp1_rdata;
            end
        end
    end

endmodule
